// File: rtl/alu_pipe_if.sv
// Handshake bus between the issuing core (master) and alu_pipe (slave).
// Carries the operand request and the registered result/status response.
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       fsl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] mul_high;
    logic [3:0]       SREG;

    modport master (
        output in_valid, A, B, fsl, out_ready,
        input  in_ready, out_valid, result, mul_high, SREG
    );

    modport slave (
        input  in_valid, A, B, fsl, out_ready,
        output in_ready, out_valid, result, mul_high, SREG
    );
endinterface

// File: rtl/alu_pipe.sv
// Parametrised 16-op ALU with valid/ready handshakes, registered {V,S,C,Z} status
// and an iterative shift-add multiplier that stalls the input side while busy.
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic       clk,
    input  logic       rst,
    alu_pipe_if.slave  bus
);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_ADDC, OP_SUBC, OP_XOR, OP_AND, OP_OR, OP_NAND,
        OP_LSL, OP_LSR, OP_ASL, OP_ASR, OP_ROL, OP_ROR, OP_MUL, OP_CMP
    } op_e;

    typedef enum logic {S_IDLE, S_MUL} state_e;

    state_e           state_q, state_d;
    op_e              op;
    logic [WIDTH-1:0] a, b;
    logic [SHW-1:0]   n;
    logic             in_ready, accept, mul_busy, mul_last;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q, mul_high_q;
    logic [3:0]       sreg_q;

    logic [WIDTH-1:0] mcand_q, acc_hi_q, acc_lo_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_d, mul_lo_d;

    assign op = op_e'(bus.fsl);
    assign a  = bus.A;
    assign b  = bus.B;
    assign n  = bus.B[SHW-1:0];

    // ---------------------------------------------------------------- ALU core
    logic             cin;
    logic [WIDTH:0]   sum, diff, shl, shr, sar;
    logic [2*WIDTH-1:0] rot_l, rot_r;
    logic [WIDTH-1:0] alu_res;
    logic             alu_v, alu_s, alu_c, alu_z;

    // Carry-in comes from the flag register as it stands when the op is accepted.
    assign cin   = ((op == OP_ADDC) || (op == OP_SUBC)) && sreg_q[1];
    assign sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign diff  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
    assign shl   = {1'b0, a} << n;
    assign shr   = {a, 1'b0} >> n;
    assign sar   = $signed({a, 1'b0}) >>> n;
    assign rot_l = {a, a} << n;
    assign rot_r = {a, a} >> n;

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        alu_res = '0;
        alu_v   = 1'b0;
        alu_c   = 1'b0;
        unique case (op)
            OP_ADD, OP_ADDC: begin
                alu_res = sum[MSB:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            OP_SUB, OP_SUBC: begin
                alu_res = diff[MSB:0];
                alu_c   = diff[WIDTH];
                alu_v   = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            OP_XOR:  alu_res = a ^ b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_NAND: alu_res = ~(a & b);
            OP_LSL, OP_ASL: begin
                alu_res = shl[MSB:0];
                alu_c   = shl[WIDTH];
            end
            OP_LSR: begin
                alu_res = shr[WIDTH:1];
                alu_c   = shr[0];
            end
            OP_ASR: begin
                alu_res = sar[WIDTH:1];
                alu_c   = sar[0];
            end
            OP_ROL: begin
                alu_res = rot_l[2*WIDTH-1:WIDTH];
                alu_c   = (n != '0) && alu_res[0];
            end
            OP_ROR: begin
                alu_res = rot_r[MSB:0];
                alu_c   = (n != '0) && alu_res[MSB];
            end
            default: alu_res = '0;
        endcase

        alu_z = (alu_res == '0);
        alu_s = alu_res[MSB];
        if (op == OP_CMP) begin
            alu_z = (a == b);
            alu_c = (a < b);
            alu_s = ($signed(a) < $signed(b));
        end
    end

    // ------------------------------------------------------------- control FSM
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept && (op == OP_MUL)) state_d = S_MUL;
            S_MUL:  if (mul_last)                 state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
        mul_busy = (state_q == S_MUL);
    end

    assign accept   = bus.in_valid && in_ready;
    assign mul_last = mul_busy && (cnt_q == SHW'(WIDTH - 1));

    // -------------------------------------------------------------- multiplier
    // acc_hi:acc_lo is the running product; acc_lo starts as the multiplier and
    // is shifted out one bit per cycle as product bits shift in from the top.
    assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_hi_d = mul_sum[WIDTH:1];
    assign mul_lo_d = {mul_sum[0], acc_lo_q[MSB:1]};

    // NOTE: the multiplier working registers carry no reset; they are reloaded
    // on every MUL accept and are only observed while the FSM is in S_MUL.
    always_ff @(posedge clk) begin
        if (accept && (op == OP_MUL)) begin
            mcand_q  <= a;
            acc_hi_q <= '0;
            acc_lo_q <= b;
            cnt_q    <= '0;
        end else if (mul_busy) begin
            acc_hi_q <= mul_hi_d;
            acc_lo_q <= mul_lo_d;
            cnt_q    <= cnt_q + SHW'(1);
        end
    end

    // ------------------------------------------------------------ output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            mul_high_q  <= '0;
            sreg_q      <= '0;
        end else if (accept && (op != OP_MUL)) begin
            out_valid_q <= 1'b1;
            result_q    <= alu_res;
            mul_high_q  <= '0;
            sreg_q      <= {alu_v, alu_s, alu_c, alu_z};
        end else if (mul_last) begin
            out_valid_q <= 1'b1;
            result_q    <= mul_lo_d;
            mul_high_q  <= mul_hi_d;
            sreg_q      <= {1'b0, mul_hi_d[MSB], 1'b0, ({mul_hi_d, mul_lo_d} == '0)};
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.mul_high  = mul_high_q;
    assign bus.SREG      = sreg_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8): directed vector table, handshake
// and reset corner sequences, then random ops against an arithmetic reference model.
module tb_alu_pipe;
    localparam int WIDTH = 8;
    localparam int SHW   = 3;
    localparam int MASK  = (1 << WIDTH) - 1;

    localparam logic [3:0] ADD = 4'd0,  SUB = 4'd1,  ADDC = 4'd2, SUBC = 4'd3;
    localparam logic [3:0] XOR = 4'd4,  AND = 4'd5,  OR   = 4'd6, NAND = 4'd7;
    localparam logic [3:0] LSL = 4'd8,  LSR = 4'd9,  ASL  = 4'd10, ASR = 4'd11;
    localparam logic [3:0] ROL = 4'd12, ROR = 4'd13, MUL  = 4'd14, CMP = 4'd15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(WIDTH)) bus ();
    alu_pipe #(.WIDTH(WIDTH), .SHW(SHW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;
    logic model_c = 1'b0;

    typedef struct {
        string            name;
        logic [3:0]       op;
        logic [WIDTH-1:0] a, b, res, hi;
        logic [3:0]       sreg;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] res, hi;
        logic [3:0]       sreg;
    } exp_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model built from the opcode definitions with plain integer arithmetic.
    function automatic exp_t model(input int op, input int a, input int b, input logic c_reg);
        exp_t e;
        int sa, sb, n, r, full, ss, ci, hi;
        longint p;
        logic v, s, c, z;
        sa = (a >= (1 << (WIDTH - 1))) ? a - (1 << WIDTH) : a;
        sb = (b >= (1 << (WIDTH - 1))) ? b - (1 << WIDTH) : b;
        n  = b % WIDTH;
        ci = (op == 2 || op == 3) ? int'(c_reg) : 0;
        r = 0; hi = 0; p = 0; v = 0; c = 0;
        case (op)
            0, 2: begin
                full = a + b + ci; r = full & MASK; c = (full > MASK);
                ss = sa + sb + ci; v = (ss > MASK / 2) || (ss < -(MASK / 2) - 1);
            end
            1, 3: begin
                full = a - b - ci; r = full & MASK; c = (full < 0);
                ss = sa - sb - ci; v = (ss > MASK / 2) || (ss < -(MASK / 2) - 1);
            end
            4: r = a ^ b;
            5: r = a & b;
            6: r = a | b;
            7: r = ~(a & b) & MASK;
            8, 10: begin
                r = (a << n) & MASK; c = (n != 0) && (((a >> (WIDTH - n)) & 1) == 1);
            end
            9: begin
                r = a >> n; c = (n != 0) && (((a >> (n - 1)) & 1) == 1);
            end
            11: begin
                r = (sa >>> n) & MASK; c = (n != 0) && (((sa >>> (n - 1)) & 1) == 1);
            end
            12: begin
                r = a;
                for (int k = 0; k < n; k++) r = ((r << 1) | (r >> (WIDTH - 1))) & MASK;
                c = (n != 0) && ((r & 1) == 1);
            end
            13: begin
                r = a;
                for (int k = 0; k < n; k++) r = (r >> 1) | ((r & 1) << (WIDTH - 1));
                c = (n != 0) && (((r >> (WIDTH - 1)) & 1) == 1);
            end
            14: begin
                p = longint'(a) * longint'(b); r = int'(p & MASK); hi = int'(p >> WIDTH);
            end
            default: r = 0;
        endcase
        if (op == 14) begin
            z = (p == 0); s = ((hi >> (WIDTH - 1)) & 1) == 1;
        end else if (op == 15) begin
            z = (a == b); c = (a < b); s = (sa < sb);
        end else begin
            z = (r == 0); s = ((r >> (WIDTH - 1)) & 1) == 1;
        end
        e.res  = WIDTH'(r);
        e.hi   = WIDTH'(hi);
        e.sreg = {v, s, c, z};
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one op and returns #1 after the edge that accepted it.
    task automatic issue(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic ordy);
        int k;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.fsl       = op;
        bus.A         = a;
        bus.B         = b;
        bus.out_ready = ordy;
        k = 0;
        while (!bus.in_ready && k < 4 * WIDTH) begin
            @(negedge clk);
            k++;
        end
        check("accept_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic apply(input string name, input logic [3:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input exp_t e);
        int cyc;
        issue(op, a, b, 1'b1);
        cyc = 0;
        while (!bus.out_valid && cyc < 4 * WIDTH) begin
            tick();
            cyc++;
        end
        check($sformatf("%s_valid", name), bus.out_valid, 1'b1);
        check($sformatf("%s_result", name), bus.result, e.res);
        check($sformatf("%s_mul_high", name), bus.mul_high, e.hi);
        check($sformatf("%s_sreg", name), bus.SREG, e.sreg);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_c = 1'b0;
    endtask

    vec_t vecs[16];
    exp_t e;

    initial begin
        bus.in_valid  = 1'b0;
        bus.fsl       = '0;
        bus.A         = '0;
        bus.B         = '0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        repeat (2) tick();
        rst = 1'b0;

        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_result", bus.result, '0);
        check("rst_mul_high", bus.mul_high, '0);
        check("rst_sreg", bus.SREG, '0);
        check("rst_in_ready", bus.in_ready, 1'b1);

        // Order matters: ADDC and SUBC consume the carry left by the row above.
        vecs[0]  = '{"add_ff_01",  ADD,  8'hFF, 8'h01, 8'h00, 8'h00, 4'b0011};
        vecs[1]  = '{"addc_05_03", ADDC, 8'h05, 8'h03, 8'h09, 8'h00, 4'b0000};
        vecs[2]  = '{"sub_80_01",  SUB,  8'h80, 8'h01, 8'h7F, 8'h00, 4'b1000};
        vecs[3]  = '{"sub_00_01",  SUB,  8'h00, 8'h01, 8'hFF, 8'h00, 4'b0110};
        vecs[4]  = '{"subc_05_01", SUBC, 8'h05, 8'h01, 8'h03, 8'h00, 4'b0000};
        vecs[5]  = '{"asr_90_3",   ASR,  8'h90, 8'h0B, 8'hF2, 8'h00, 4'b0100};
        vecs[6]  = '{"rol_81_1",   ROL,  8'h81, 8'h01, 8'h03, 8'h00, 4'b0010};
        vecs[7]  = '{"lsl_01_0",   LSL,  8'h01, 8'h00, 8'h01, 8'h00, 4'b0000};
        vecs[8]  = '{"cmp_03_05",  CMP,  8'h03, 8'h05, 8'h00, 8'h00, 4'b0110};
        vecs[9]  = '{"xor_a5_a5",  XOR,  8'hA5, 8'hA5, 8'h00, 8'h00, 4'b0001};
        vecs[10] = '{"nand_f0_0f", NAND, 8'hF0, 8'h0F, 8'hFF, 8'h00, 4'b0100};
        vecs[11] = '{"mul_ff_ff",  MUL,  8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0100};
        vecs[12] = '{"ror_01_1",   ROR,  8'h01, 8'h01, 8'h80, 8'h00, 4'b0110};
        vecs[13] = '{"lsr_81_1",   LSR,  8'h81, 8'h09, 8'h40, 8'h00, 4'b0010};
        vecs[14] = '{"asl_81_1",   ASL,  8'h81, 8'h01, 8'h02, 8'h00, 4'b0010};
        vecs[15] = '{"cmp_80_01",  CMP,  8'h80, 8'h01, 8'h00, 8'h00, 4'b0100};

        for (int i = 0; i < 16; i++) begin
            e.res  = vecs[i].res;
            e.hi   = vecs[i].hi;
            e.sreg = vecs[i].sreg;
            apply(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, e);
        end

        // MUL latency: result due 9 cycles after the accept cycle, input side busy for 8.
        begin
            int lat, busy;
            issue(MUL, 8'hFF, 8'hFF, 1'b1);
            lat = 0;
            busy = 0;
            while (!bus.out_valid && lat < 4 * WIDTH) begin
                if (!bus.in_ready) busy++;
                tick();
                lat++;
            end
            check("mul_latency", lat + 1, WIDTH + 1);
            check("mul_busy_cycles", busy, WIDTH);
            check("mul_product", {bus.mul_high, bus.result}, 16'hFE01);
            tick();
            check("mul_consumed", bus.out_valid, 1'b0);
        end

        // Output stall: everything holds and no new op is taken until out_ready returns.
        issue(ADD, 8'h12, 8'h34, 1'b0);
        repeat (3) begin
            tick();
            check("stall_valid", bus.out_valid, 1'b1);
            check("stall_result", bus.result, 8'h46);
            check("stall_sreg", bus.SREG, 4'b0000);
            check("stall_in_ready", bus.in_ready, 1'b0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.fsl       = XOR;
        bus.A         = 8'h0F;
        bus.B         = 8'hF0;
        #1;
        check("release_in_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check("release_valid", bus.out_valid, 1'b1);
        check("release_result", bus.result, 8'hFF);
        check("release_sreg", bus.SREG, 4'b0100);
        tick();

        // Reset in the 4th cycle of a multiply: the product must never surface.
        begin
            int rises;
            issue(MUL, 8'h10, 8'h10, 1'b1);
            repeat (2) tick();
            do_reset();
            check("abort_out_valid", bus.out_valid, 1'b0);
            check("abort_sreg", bus.SREG, 4'b0000);
            check("abort_in_ready", bus.in_ready, 1'b1);
            rises = 0;
            repeat (2 * WIDTH) begin
                tick();
                if (bus.out_valid) rises++;
            end
            check("abort_no_result", rises, 0);
        end

        // Random ops against the reference model; carry chains through model_c.
        for (int i = 0; i < 300; i++) begin
            logic [3:0]       op;
            logic [WIDTH-1:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = WIDTH'($urandom);
            b  = WIDTH'($urandom);
            e  = model(int'(op), int'(a), int'(b), model_c);
            apply($sformatf("rand%0d_op%0d", i, op), op, a, b, e);
            model_c = e.sreg[1];
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
